// File: rtl/decode_hazard_unit_if.sv
// Decode-stage hazard interface: decode instruction fields and pipeline control in,
// pipeline enables, bubble select and scoreboard status out.
interface decode_hazard_unit_if #(
    parameter int REG_W  = 3,
    parameter int STAT_W = 16
);
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic              id_rs_used;
    logic [REG_W-1:0]  id_rt;
    logic              id_rt_used;
    logic              id_wr_en;
    logic [REG_W-1:0]  id_wr_reg;
    logic              id_is_load;
    logic              ex_br_taken;
    logic              mem_stall;
    logic              fd_en;
    logic              dex_en;
    logic              dex_bubble;
    logic              issue;
    logic              sb_busy;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_wr_en, id_wr_reg, id_is_load, ex_br_taken, mem_stall,
        input  fd_en, dex_en, dex_bubble, issue, sb_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_wr_en, id_wr_reg, id_is_load, ex_br_taken, mem_stall,
        output fd_en, dex_en, dex_bubble, issue, sb_busy, stall_cycles
    );
endinterface

// File: rtl/decode_hazard_unit.sv
// Decode-stage RAW hazard detection with a per-register countdown scoreboard,
// branch flush / memory stall priority and a saturating stall-cycle counter.
module decode_hazard_unit #(
    parameter int NREG     = 8,
    parameter int CNT_W    = 2,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    decode_hazard_unit_if.slave hz
);
    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [STAT_W-1:0] stall_cycles_q;
    logic [STAT_W-1:0] stall_cycles_d;
    logic              raw;
    logic              busy;
    logic              fd_en;
    logic              dex_en;
    logic              dex_bubble;
    logic              issue;

    // Hazard looks only at registered counts, so a producer reading its own
    // destination sees the pre-update value and never stalls on itself.
    always_comb begin
        raw = hz.id_valid &
              ((hz.id_rs_used & (cnt_q[hz.id_rs] != '0)) |
               (hz.id_rt_used & (cnt_q[hz.id_rt] != '0)));
        busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            busy = busy | (cnt_q[i] != '0);
        end
    end

    always_comb begin
        fd_en      = 1'b1;
        dex_en     = 1'b1;
        dex_bubble = ~hz.id_valid;
        issue      = hz.id_valid;
        if (hz.mem_stall) begin
            fd_en      = 1'b0;
            dex_en     = 1'b0;
            dex_bubble = 1'b0;
            issue      = 1'b0;
        end else if (hz.ex_br_taken) begin
            dex_bubble = 1'b1;
            issue      = 1'b0;
        end else if (raw) begin
            fd_en      = 1'b0;
            dex_bubble = 1'b1;
            issue      = 1'b0;
        end
    end

    // Age every pending producer, then let the issuing writer overwrite its
    // destination so the youngest writer's latency wins.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        stall_cycles_d = stall_cycles_q;
        if (!hz.mem_stall) begin
            for (int i = 0; i < NREG; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            if (issue && hz.id_wr_en) begin
                cnt_d[hz.id_wr_reg] = hz.id_is_load ? LOAD_CNT : ALU_CNT;
            end
            if (raw && !hz.ex_br_taken && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.fd_en        = fd_en;
    assign hz.dex_en       = dex_en;
    assign hz.dex_bubble   = dex_bubble;
    assign hz.issue        = issue;
    assign hz.sb_busy      = busy;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_decode_hazard_unit.sv
// Scoreboard bench for decode_hazard_unit: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_decode_hazard_unit;
    logic clk;
    logic rst;

    decode_hazard_unit_if #(.REG_W(3), .STAT_W(16)) hz ();

    decode_hazard_unit #(
        .NREG(8), .CNT_W(2), .ALU_LAT(0), .LOAD_LAT(1), .STAT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] rs;
        logic       rs_used;
        logic [2:0] rt;
        logic       rt_used;
        logic       wr_en;
        logic [2:0] wr_reg;
        logic       is_load;
        logic       br;
        logic       ms;
    } vec_t;

    typedef struct packed {
        logic        fd_en;
        logic        dex_en;
        logic        dex_bubble;
        logic        issue;
        logic        sb_busy;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t ins(input logic valid, input logic [2:0] rs, input logic rs_used,
                                 input logic [2:0] rt, input logic rt_used, input logic wr_en,
                                 input logic [2:0] wr_reg, input logic is_load,
                                 input logic br, input logic ms);
        vec_t v;
        v = '{valid, rs, rs_used, rt, rt_used, wr_en, wr_reg, is_load, br, ms};
        return v;
    endfunction

    function automatic exp_t ex(input logic fd, input logic dex, input logic bub,
                                input logic iss, input logic busy, input int st);
        exp_t e;
        e = '{fd, dex, bub, iss, busy, 16'(st)};
        return e;
    endfunction

    task automatic apply_stimulus(input vec_t v, input exp_t e);
        @(posedge clk);
        #1;
        hz.id_valid    = v.valid;
        hz.id_rs       = v.rs;
        hz.id_rs_used  = v.rs_used;
        hz.id_rt       = v.rt;
        hz.id_rt_used  = v.rt_used;
        hz.id_wr_en    = v.wr_en;
        hz.id_wr_reg   = v.wr_reg;
        hz.id_is_load  = v.is_load;
        hz.ex_br_taken = v.br;
        hz.mem_stall   = v.ms;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        exp_t a;
        a = '{hz.fd_en, hz.dex_en, hz.dex_bubble, hz.issue, hz.sb_busy, hz.stall_cycles};
        vectors_applied++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got fd=%b dex=%b bub=%b iss=%b busy=%b stall=%0d, want fd=%b dex=%b bub=%b iss=%b busy=%b stall=%0d",
                     vectors_applied, a.fd_en, a.dex_en, a.dex_bubble, a.issue, a.sb_busy, a.stall,
                     e.fd_en, e.dex_en, e.dex_bubble, e.issue, e.sb_busy, e.stall);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                check_output(exp_q.pop_front());
            end
        end
    end

    initial begin
        vec_t idle;
        idle = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst            = 1'b0;
        hz.id_valid    = 1'b0;
        hz.id_rs       = '0;
        hz.id_rs_used  = 1'b0;
        hz.id_rt       = '0;
        hz.id_rt_used  = 1'b0;
        hz.id_wr_en    = 1'b0;
        hz.id_wr_reg   = '0;
        hz.id_is_load  = 1'b0;
        hz.ex_br_taken = 1'b0;
        hz.mem_stall   = 1'b0;

        // reset state with an empty decode slot
        apply_stimulus(idle, ex(1, 1, 1, 0, 0, 0));
        apply_stimulus(idle, ex(1, 1, 1, 0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b1;

        // ALU add r3, then consumer of r3: full forwarding, no stall
        apply_stimulus(ins(1, 1, 1, 2, 1, 1, 3, 0, 0, 0), ex(1, 1, 0, 1, 0, 0));
        apply_stimulus(ins(1, 3, 1, 0, 0, 1, 4, 0, 0, 0), ex(1, 1, 0, 1, 0, 0));

        // load r1, consumer reads r1 on rt: one bubble
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ex(1, 1, 0, 1, 0, 0));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 0), ex(0, 1, 1, 0, 1, 0));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 1));

        // load-use with three cycles of memory stall freezing the scoreboard
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ex(1, 1, 0, 1, 0, 1));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 1), ex(0, 0, 0, 0, 1, 1));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 1), ex(0, 0, 0, 0, 1, 1));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 1), ex(0, 0, 0, 0, 1, 1));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 0), ex(0, 1, 1, 0, 1, 1));
        apply_stimulus(ins(1, 2, 1, 1, 1, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 2));

        // load r2, dependent squashed by a taken branch: flush beats raw
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 2, 1, 0, 0), ex(1, 1, 0, 1, 0, 2));
        apply_stimulus(ins(1, 2, 1, 0, 0, 1, 7, 1, 1, 0), ex(1, 1, 1, 0, 1, 2));
        apply_stimulus(idle, ex(1, 1, 1, 0, 0, 2));

        // load r5 then ALU write r5 overwrites the countdown to zero
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 5, 1, 0, 0), ex(1, 1, 0, 1, 0, 2));
        apply_stimulus(ins(1, 0, 1, 0, 0, 1, 5, 0, 0, 0), ex(1, 1, 0, 1, 1, 2));
        apply_stimulus(ins(1, 5, 1, 0, 0, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 2));

        // back-to-back loads of r5: second one re-arms the countdown
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 5, 1, 0, 0), ex(1, 1, 0, 1, 0, 2));
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 5, 1, 0, 0), ex(1, 1, 0, 1, 1, 2));
        apply_stimulus(ins(1, 0, 0, 5, 1, 1, 6, 0, 0, 0), ex(0, 1, 1, 0, 1, 2));
        apply_stimulus(ins(1, 0, 0, 5, 1, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 3));

        // same register on both sources stalls only once
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 4, 1, 0, 0), ex(1, 1, 0, 1, 0, 3));
        apply_stimulus(ins(1, 4, 1, 4, 1, 1, 6, 0, 0, 0), ex(0, 1, 1, 0, 1, 3));
        apply_stimulus(ins(1, 4, 1, 4, 1, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 4));

        // unused source fields never create a hazard
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 3, 1, 0, 0), ex(1, 1, 0, 1, 0, 4));
        apply_stimulus(ins(1, 3, 0, 3, 0, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 1, 4));

        // reset asserted mid-stall clears the pending hazard and the counter
        apply_stimulus(ins(1, 0, 0, 0, 0, 1, 4, 1, 0, 0), ex(1, 1, 0, 1, 0, 4));
        apply_stimulus(ins(1, 4, 1, 0, 0, 1, 6, 0, 0, 0), ex(0, 1, 1, 0, 1, 4));
        @(negedge clk);
        #2 rst = 1'b0;
        apply_stimulus(ins(1, 4, 1, 0, 0, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 0));
        @(posedge clk);
        #1 rst = 1'b1;
        apply_stimulus(ins(1, 4, 1, 0, 0, 1, 6, 0, 0, 0), ex(1, 1, 0, 1, 0, 0));
        apply_stimulus(idle, ex(1, 1, 1, 0, 0, 0));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
